// File: rtl/tamagotchi_btn_conditioner.sv
// Button front end for tamagotchi_fsm: synchronise, debounce and edge-detect six buttons,
// plus hold-second counters, long-press pulses and a sticky test_mode for reset/test.
module tamagotchi_btn_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int TICK_CYCLES     = 50_000_000,
  parameter int HOLD_SECONDS    = 5,
  parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] btn_raw,
  output logic [5:0] btn_level,
  output logic [5:0] btn_press,
  output logic [2:0] count_reset,
  output logic [2:0] count_test,
  output logic       long_reset,
  output logic       long_test,
  output logic       test_mode
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int TK_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TK_W-1:0] TK_LAST = TK_W'(TICK_CYCLES - 1);
  localparam logic [2:0]      HOLD_S  = 3'(HOLD_SECONDS);

  logic [5:0]      raw_s;
  logic [5:0]      sync1_r;
  logic [5:0]      sync2_r;
  logic [5:0]      level_r;
  logic [5:0]      level_s;
  logic [5:0]      press_r;
  logic [5:0]      press_s;
  logic [DB_W-1:0] db_cnt_r [6];
  logic [DB_W-1:0] db_cnt_s [6];
  // Hold channels: index 0 = reset button (bit4), index 1 = test button (bit5).
  logic [TK_W-1:0] tick_r [2];
  logic [TK_W-1:0] tick_s [2];
  logic [2:0]      sec_r [2];
  logic [2:0]      sec_s [2];
  logic            hit_s [2];
  logic            long_reset_r;
  logic            long_reset_s;
  logic            long_test_r;
  logic            long_test_s;
  logic            test_mode_r;
  logic            test_mode_s;

  assign raw_s = BTN_ACTIVE_LOW ? ~btn_raw : btn_raw;

  // Debounce: accept a new level only after DEBOUNCE_CYCLES consecutive mismatches.
  always_comb begin
    level_s = level_r;
    press_s = 6'b000000;
    for (int i = 0; i < 6; i++) begin
      db_cnt_s[i] = '0;
      if (sync2_r[i] == level_r[i]) begin
        db_cnt_s[i] = '0;
      end else if (db_cnt_r[i] == DB_LAST) begin
        level_s[i]  = sync2_r[i];
        press_s[i]  = sync2_r[i];
        db_cnt_s[i] = '0;
      end else begin
        db_cnt_s[i] = db_cnt_r[i] + DB_W'(1);
      end
    end
  end

  // Hold timers, long-press detection and test_mode arbitration (reset wins).
  always_comb begin
    for (int c = 0; c < 2; c++) begin
      tick_s[c] = '0;
      sec_s[c]  = 3'd0;
      hit_s[c]  = 1'b0;
      if (level_r[4 + c]) begin
        if (tick_r[c] == TK_LAST) begin
          tick_s[c] = '0;
          if (sec_r[c] != HOLD_S) begin
            sec_s[c] = sec_r[c] + 3'd1;
            hit_s[c] = ((sec_r[c] + 3'd1) == HOLD_S);
          end else begin
            sec_s[c] = sec_r[c];
          end
        end else begin
          tick_s[c] = tick_r[c] + TK_W'(1);
          sec_s[c]  = sec_r[c];
        end
      end else begin
        tick_s[c] = '0;
        sec_s[c]  = 3'd0;
      end
    end
    long_reset_s = hit_s[0];
    long_test_s  = hit_s[1] & ~hit_s[0];
    if (long_reset_s) begin
      test_mode_s = 1'b0;
    end else if (long_test_s) begin
      test_mode_s = ~test_mode_r;
    end else begin
      test_mode_s = test_mode_r;
    end
  end

  // State registers; synchroniser flops reset to the idle (not-pressed) value.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_r      <= 6'b000000;
      sync2_r      <= 6'b000000;
      level_r      <= 6'b000000;
      press_r      <= 6'b000000;
      long_reset_r <= 1'b0;
      long_test_r  <= 1'b0;
      test_mode_r  <= 1'b0;
      for (int i = 0; i < 6; i++) begin
        db_cnt_r[i] <= '0;
      end
      for (int c = 0; c < 2; c++) begin
        tick_r[c] <= '0;
        sec_r[c]  <= 3'd0;
      end
    end else begin
      sync1_r      <= raw_s;
      sync2_r      <= sync1_r;
      level_r      <= level_s;
      press_r      <= press_s;
      long_reset_r <= long_reset_s;
      long_test_r  <= long_test_s;
      test_mode_r  <= test_mode_s;
      for (int i = 0; i < 6; i++) begin
        db_cnt_r[i] <= db_cnt_s[i];
      end
      for (int c = 0; c < 2; c++) begin
        tick_r[c] <= tick_s[c];
        sec_r[c]  <= sec_s[c];
      end
    end
  end

  assign btn_level   = level_r;
  assign btn_press   = press_r;
  assign count_reset = sec_r[0];
  assign count_test  = sec_r[1];
  assign long_reset  = long_reset_r;
  assign long_test   = long_test_r;
  assign test_mode   = test_mode_r;

endmodule

// File: tb/tb_tamagotchi_btn_conditioner.sv
// Scoreboard bench: stimulus queues the expected output bundle and its cycle for every
// output change; a negedge monitor pops and compares whenever the outputs change.
module tb_tamagotchi_btn_conditioner;

  typedef struct packed {
    logic [5:0] level;
    logic [5:0] press;
    logic [2:0] cr;
    logic [2:0] ct;
    logic       lr;
    logic       lt;
    logic       tm;
  } obs_t;

  typedef struct {
    int   cyc;
    obs_t val;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] btn_raw;
  logic [5:0] btn_level;
  logic [5:0] btn_press;
  logic [2:0] count_reset;
  logic [2:0] count_test;
  logic       long_reset;
  logic       long_test;
  logic       test_mode;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic rst_at_edge = 1'b0;
  obs_t m;
  obs_t cur;
  obs_t prev = '0;
  exp_t q[$];
  exp_t e;
  int   d;
  int   ee;

  tamagotchi_btn_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .TICK_CYCLES(10),
    .HOLD_SECONDS(5),
    .BTN_ACTIVE_LOW(1'b0)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn_raw(btn_raw),
    .btn_level(btn_level),
    .btn_press(btn_press),
    .count_reset(count_reset),
    .count_test(count_test),
    .long_reset(long_reset),
    .long_test(long_test),
    .test_mode(test_mode)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc         <= cyc + 1;
    rst_at_edge <= reset;
  end

  // Monitor: reset-state check while reset was sampled, and event compare on any change.
  always @(negedge clk) begin
    cur = {btn_level, btn_press, count_reset, count_test, long_reset, long_test, test_mode};
    if (rst_at_edge) begin
      checks++;
      if (cur !== '0) begin
        errors++;
        $display("FAIL reset_state cyc=%0d got=%h exp=0", cyc, cur);
      end
    end
    if (cur !== prev) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_change cyc=%0d got=%h", cyc, cur);
      end else begin
        e = q.pop_front();
        if (e.cyc != cyc || e.val !== cur) begin
          errors++;
          $display("FAIL event cyc got=%0d exp=%0d bundle got=%h exp=%h", cyc, e.cyc, cur, e.val);
        end
      end
      prev = cur;
    end
  end

  task automatic ex(input int c);
    exp_t x;
    x.cyc = c;
    x.val = m;
    q.push_back(x);
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Hold the test button for 70 cycles: five seconds, one long_test, test_mode toggles.
  task automatic hold_test_70();
    btn_raw[5] = 1'b1;
    d  = cyc;
    ee = d + 6;
    m.level[5] = 1'b1; m.press[5] = 1'b1; ex(ee);
    m.press[5] = 1'b0; ex(ee + 1);
    for (int s = 1; s < 5; s++) begin
      m.ct = 3'(s); ex(ee + 10 * s);
    end
    m.ct = 3'd5; m.lt = 1'b1; m.tm = ~m.tm; ex(ee + 50);
    m.lt = 1'b0; ex(ee + 51);
    wait_cyc(d + 70);
    btn_raw[5] = 1'b0;
    m.level[5] = 1'b0; ex(d + 76);
    m.ct = 3'd0; ex(d + 77);
    wait_cyc(d + 80);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d expected bench to end before this", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    m = '0;
    // 1: reset with all buttons high, then full debounce after release.
    reset = 1'b1;
    btn_raw = 6'h3F;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    d = cyc;
    m.level = 6'h3F; m.press = 6'h3F; ex(d + 6);
    m.press = 6'h00; ex(d + 7);
    wait_cyc(d + 7);
    btn_raw = 6'h00;
    d = cyc;
    m.level = 6'h00; ex(d + 6);
    wait_cyc(d + 10);

    // 2: bounce salud five times, then hold it.
    for (int k = 0; k < 5; k++) begin
      btn_raw[0] = 1'b1;
      wait_cyc(cyc + 2);
      btn_raw[0] = 1'b0;
      wait_cyc(cyc + 2);
    end
    btn_raw[0] = 1'b1;
    d = cyc;
    m.level[0] = 1'b1; m.press[0] = 1'b1; ex(d + 6);
    m.press[0] = 1'b0; ex(d + 7);
    wait_cyc(d + 10);
    btn_raw[0] = 1'b0;
    d = cyc;
    m.level[0] = 1'b0; ex(d + 6);
    wait_cyc(d + 10);

    // 3: diversion high for only three cycles is rejected.
    btn_raw[3] = 1'b1;
    wait_cyc(cyc + 3);
    btn_raw[3] = 1'b0;
    wait_cyc(cyc + 10);

    // 4: long test press sets test_mode, a second one clears it.
    hold_test_70();
    hold_test_70();

    // 5: reset and test held together; reset wins, long_test suppressed.
    btn_raw[5:4] = 2'b11;
    d  = cyc;
    ee = d + 6;
    m.level = 6'h30; m.press = 6'h30; ex(ee);
    m.press = 6'h00; ex(ee + 1);
    for (int s = 1; s < 5; s++) begin
      m.cr = 3'(s); m.ct = 3'(s); ex(ee + 10 * s);
    end
    m.cr = 3'd5; m.ct = 3'd5; m.lr = 1'b1; m.lt = 1'b0; m.tm = 1'b0; ex(ee + 50);
    m.lr = 1'b0; ex(ee + 51);
    wait_cyc(d + 70);
    btn_raw[5:4] = 2'b00;
    m.level = 6'h00; ex(d + 76);
    m.cr = 3'd0; m.ct = 3'd0; ex(d + 77);
    wait_cyc(d + 80);

    // 6: reset asserted mid-hold discards progress; button re-debounces.
    btn_raw[4] = 1'b1;
    d  = cyc;
    ee = d + 6;
    m.level[4] = 1'b1; m.press[4] = 1'b1; ex(ee);
    m.press[4] = 1'b0; ex(ee + 1);
    for (int s = 1; s < 4; s++) begin
      m.cr = 3'(s); ex(ee + 10 * s);
    end
    wait_cyc(ee + 30);
    reset = 1'b1;
    m = '0; ex(ee + 31);
    wait_cyc(ee + 31);
    reset = 1'b0;
    d = cyc;
    m.level[4] = 1'b1; m.press[4] = 1'b1; ex(d + 6);
    m.press[4] = 1'b0; ex(d + 7);
    m.cr = 3'd1; ex(d + 16);
    wait_cyc(d + 18);
    btn_raw[4] = 1'b0;
    m.level[4] = 1'b0; ex(d + 24);
    m.cr = 3'd0; ex(d + 25);
    wait_cyc(d + 30);

    while (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      errors++;
      $display("FAIL missing_event exp_cyc=%0d exp=%h never seen", e.cyc, e.val);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
